// File: rtl/dna_code_pkg.sv
// Shared types and constants for the quaternary VT-style code: word length,
// residue, modulus and the differential-symbol helper.
package dna_code_pkg;

  localparam int N     = 98;
  localparam int A     = 24;
  localparam int MOD   = 4 * N;
  localparam int SYN_W = 14;
  localparam int SUM_W = 9;
  localparam int IDX_W = 7;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } vtgen_state_t;

  // Differential symbol (cur - prev) mod 4; the 2-bit wrap is the modulo.
  function automatic sym_t diff4(sym_t cur, sym_t prev);
    sym_t d;
    d = cur - prev;
    return d;
  endfunction

endpackage

// File: rtl/vt4_syndrome_gen_mod_acc.sv
// Bounded modular accumulator: acc stays in [0, MOD) given term < MOD, so one
// conditional subtract per update is enough.
module vt4_mod_acc
  import dna_code_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [SYN_W-1:0] term,
  output logic [SYN_W-1:0] acc
);

  localparam logic [SYN_W:0] MOD_W = (SYN_W+1)'(MOD);

  logic [SYN_W-1:0] acc_q;
  logic [SYN_W-1:0] acc_d;
  logic [SYN_W:0]   sum_w;
  logic [SYN_W:0]   red_w;

  always_comb begin
    sum_w = {1'b0, acc_q} + {1'b0, term};
    red_w = sum_w - MOD_W;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = (sum_w >= MOD_W) ? red_w[SYN_W-1:0] : sum_w[SYN_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/vt4_syndrome_gen.sv
// Encoder-side syndrome generator: consumes one quaternary symbol per beat and
// reports differential weight, weighted syndrome mod 4N and the check value.
module vt4_syndrome_gen
  import dna_code_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sym,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_word_sum,
  output logic [SYN_W-1:0] out_syn,
  output logic [SYN_W-1:0] out_check,
  output logic             out_err
);

  // Handshake: a beat moves when in_valid & in_ready on a rising edge; the
  // result moves when out_valid & out_ready; valid never depends on ready.

  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N);
  localparam logic [SYN_W-1:0] MOD_S = SYN_W'(MOD);
  localparam logic [SYN_W-1:0] A_MOD = SYN_W'(A % MOD);

  vtgen_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  sym_t             prev_q, prev_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             err_q, err_d;

  logic             accept;
  sym_t             d_sym;
  logic [SYN_W-1:0] term;
  logic [SYN_W-1:0] acc;
  logic             acc_clear;
  logic             word_end;

  assign accept = in_valid && (state_q == ACCUM);
  assign d_sym  = diff4(in_sym, prev_q);
  assign term   = {{(SYN_W-IDX_W){1'b0}}, idx_q} * {{(SYN_W-2){1'b0}}, d_sym};
  assign acc_clear = (state_q == IDLE);
  assign word_end  = accept && (in_last || (idx_q == N_IDX));

  vt4_mod_acc u_mod_acc (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear),
    .en    (accept),
    .term  (term),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= prev_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prev_d  = prev_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        state_d = ACCUM;
        idx_d   = IDX_W'(1);
        prev_d  = '0;
        sum_d   = '0;
        err_d   = 1'b0;
      end
      ACCUM: begin
        if (accept) begin
          prev_d = in_sym;
          sum_d  = sum_q + {{(SUM_W-2){1'b0}}, d_sym};
          idx_d  = idx_q + IDX_W'(1);
        end
        if (word_end) begin
          state_d = DONE;
          // Early last and a full word without last are both length errors.
          err_d   = in_last ? (idx_q != N_IDX) : 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == ACCUM);
    out_valid    = (state_q == DONE);
    out_word_sum = '0;
    out_syn      = '0;
    out_check    = '0;
    out_err      = 1'b0;
    if (state_q == DONE) begin
      out_word_sum = sum_q;
      out_syn      = acc;
      out_check    = (acc > A_MOD) ? (A_MOD + MOD_S - acc) : (A_MOD - acc);
      out_err      = err_q;
    end
  end

endmodule

// File: tb/tb_vt4_syndrome_gen.sv
// Self-checking bench for vt4_syndrome_gen: words driven beat by beat, results
// predicted by an independent model and matched through an expected queue.
module tb_vt4_syndrome_gen;

  localparam int NW  = 98;
  localparam int AV  = 24;
  localparam int MV  = 4 * NW;
  localparam int EXP_W = 1 + 14 + 14 + 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sym;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_word_sum;
  logic [13:0] out_syn;
  logic [13:0] out_check;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       sym_arr[1:128];

  vt4_syndrome_gen dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sym       (in_sym),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word_sum (out_word_sum),
    .out_syn      (out_syn),
    .out_check    (out_check),
    .out_err      (out_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Independent reference: walks the stored symbols and forms the packed
  // {err, check, syn, sum} the DUT must report.
  function automatic logic [EXP_W-1:0] model(input int len, input bit use_last);
    int prev, d, sum, syn, chk;
    bit err;
    prev = 0; sum = 0; syn = 0;
    for (int i = 1; i <= len; i++) begin
      d    = (int'(sym_arr[i]) - prev + 4) % 4;
      sum  = sum + d;
      syn  = (syn + i * d) % MV;
      prev = int'(sym_arr[i]);
    end
    chk = ((AV - syn) % MV + MV) % MV;
    err = use_last ? (len != NW) : 1'b1;
    return {err, 14'(chk), 14'(syn), 9'(sum)};
  endfunction

  task automatic fill(input int pat);
    for (int i = 1; i <= 128; i++) begin
      case (pat)
        0: sym_arr[i] = 2'd0;
        1: sym_arr[i] = (i == 1) ? 2'd1 : 2'd0;
        2: sym_arr[i] = 2'd3;
        3: sym_arr[i] = 2'(i % 4);
        default: sym_arr[i] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Drives len beats; called just after a rising edge, returns just after one.
  task automatic drive_beats(input int len, input bit use_last, input bit gaps);
    int wait_cnt;
    for (int i = 1; i <= len; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_sym   = sym_arr[i];
      in_last  = use_last && (i == len);
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        wait_cnt++;
        if (wait_cnt > 200) break;
      end
      if (wait_cnt > 200) begin
        check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input int pat, input int len, input bit use_last, input bit gaps);
    fill(pat);
    exp_q.push_back(model(len, use_last));
    drive_beats(len, use_last, gaps);
    @(negedge clk);
    check_eq("out_valid_latency", 64'(out_valid), 64'd1);
    check_eq("in_ready_in_done", 64'(in_ready), 64'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("word_sum", 64'(out_word_sum), 64'(e[8:0]));
        check_eq("syn",      64'(out_syn),      64'(e[22:9]));
        check_eq("check",    64'(out_check),    64'(e[36:23]));
        check_eq("err",      64'(out_err),      64'(e[37]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [EXP_W-1:0] bp_e;
    int drain;
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  64'(in_ready),     64'd0);
    check_eq("rst_out_valid", 64'(out_valid),    64'd0);
    check_eq("rst_word_sum",  64'(out_word_sum), 64'd0);
    check_eq("rst_syn",       64'(out_syn),      64'd0);
    check_eq("rst_check",     64'(out_check),    64'd0);
    check_eq("rst_err",       64'(out_err),      64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send_word(0, NW, 1'b1, 1'b0);   // all zero
    send_word(1, NW, 1'b1, 1'b0);   // x1=1
    send_word(2, NW, 1'b1, 1'b0);   // all 3
    send_word(3, NW, 1'b1, 1'b1);   // i mod 4 with gaps
    send_word(4, NW, 1'b1, 1'b1);   // random
    send_word(4, 50, 1'b1, 1'b0);   // early last
    send_word(3, NW, 1'b0, 1'b0);   // overrun without last
    send_word(3, 1,  1'b1, 1'b0);   // single-beat word

    // Backpressure: result must hold steady while out_ready is low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fill(2);
    bp_e = model(NW, 1'b1);
    exp_q.push_back(bp_e);
    drive_beats(NW, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 64'(out_valid),    64'd1);
      check_eq("bp_in_ready",  64'(in_ready),     64'd0);
      check_eq("bp_word_sum",  64'(out_word_sum), 64'(bp_e[8:0]));
      check_eq("bp_syn",       64'(out_syn),      64'(bp_e[22:9]));
      check_eq("bp_check",     64'(out_check),    64'(bp_e[36:23]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-word at beat 40: partial word is dropped.
    fill(3);
    drive_beats(39, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_sym   = sym_arr[40];
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready",  64'(in_ready),     64'd0);
    check_eq("midrst_out_valid", 64'(out_valid),    64'd0);
    check_eq("midrst_word_sum",  64'(out_word_sum), 64'd0);
    check_eq("midrst_syn",       64'(out_syn),      64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(3, NW, 1'b1, 1'b1);

    drain = 0;
    while (exp_q.size() != 0 && drain < 500) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
